// File: rtl/csr_timer_bank.sv
// CSR-mapped bank of countdown timers sharing one prescaler.
// Each channel runs one-shot or periodic and has a sticky, software-clearable interrupt.
module csr_timer_bank #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRESC_W    = 8,
  parameter logic [13:0] CSR_BASE   = 14'h0100
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_we,
  input  logic [13:0]           csr_num,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_hit,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any
);

  localparam logic [13:0] PRESC_OFF = 14'(4 * NUM_TIMERS);

  function automatic logic [CNT_W-1:0] merge_cfg(input logic [CNT_W-1:0] old_v,
                                                 input logic [CNT_W-1:0] mask_v,
                                                 input logic [CNT_W-1:0] data_v);
    return (mask_v & data_v) | (~mask_v & old_v);
  endfunction

  // Reload value is the CFG word with EN/PER forced to zero.
  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] cfg_v);
    logic [CNT_W-1:0] r;
    r      = cfg_v;
    r[1:0] = 2'b00;
    return r;
  endfunction

  logic [13:0]           off_s;
  logic [11:0]           ch_s;
  logic [1:0]            reg_s;
  logic                  in_map_s;
  logic                  in_chan_s;
  logic                  is_presc_s;
  logic                  presc_wr_s;
  logic                  tick_s;
  logic [NUM_TIMERS-1:0] cfg_wr_s;
  logic [NUM_TIMERS-1:0] clr_wr_s;
  logic [NUM_TIMERS-1:0] expire_s;
  logic [31:0]           rdata_s;

  logic [CNT_W-1:0]      cfg_q [NUM_TIMERS];
  logic [CNT_W-1:0]      cfg_d [NUM_TIMERS];
  logic [CNT_W-1:0]      val_q [NUM_TIMERS];
  logic [CNT_W-1:0]      val_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] pend_q;
  logic [NUM_TIMERS-1:0] pend_d;
  logic [PRESC_W-1:0]    presc_q;
  logic [PRESC_W-1:0]    presc_d;
  logic [PRESC_W-1:0]    pcnt_q;
  logic [PRESC_W-1:0]    pcnt_d;

  assign off_s      = csr_num - CSR_BASE;
  assign ch_s       = off_s[13:2];
  assign reg_s      = off_s[1:0];
  assign in_map_s   = (csr_num >= CSR_BASE) && (off_s <= PRESC_OFF);
  assign in_chan_s  = in_map_s && (off_s < PRESC_OFF);
  assign is_presc_s = in_map_s && (off_s == PRESC_OFF);
  assign presc_wr_s = csr_we && is_presc_s;
  // A PRESC write restarts the prescaler, so the tick in that cycle is dropped.
  assign tick_s     = (pcnt_q == {PRESC_W{1'b0}}) && !presc_wr_s;

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (presc_wr_s) begin
      presc_d = (csr_wmask[PRESC_W-1:0] & csr_wdata[PRESC_W-1:0]) |
                (~csr_wmask[PRESC_W-1:0] & presc_q);
      pcnt_d  = presc_d;
    end else if (pcnt_q == {PRESC_W{1'b0}}) begin
      pcnt_d = presc_q;
    end else begin
      pcnt_d = pcnt_q - PRESC_W'(1);
    end
  end

  always_comb begin
    cfg_wr_s = {NUM_TIMERS{1'b0}};
    clr_wr_s = {NUM_TIMERS{1'b0}};
    expire_s = {NUM_TIMERS{1'b0}};
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cfg_wr_s[i] = csr_we && in_chan_s && (ch_s == 12'(i)) && (reg_s == 2'd0);
      clr_wr_s[i] = csr_we && in_chan_s && (ch_s == 12'(i)) && (reg_s == 2'd2) &&
                    csr_wmask[0] && csr_wdata[0];
      expire_s[i] = tick_s && cfg_q[i][0] && (val_q[i] == {CNT_W{1'b0}});
    end
  end

  // Expiry is judged on the old state; a CFG write then overrides EN and VAL.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cfg_d[i]  = cfg_q[i];
      val_d[i]  = val_q[i];
      pend_d[i] = pend_q[i];
      if (tick_s && cfg_q[i][0]) begin
        if (val_q[i] != {CNT_W{1'b0}}) begin
          val_d[i] = val_q[i] - CNT_W'(1);
        end else if (cfg_q[i][1]) begin
          val_d[i] = reload_of(cfg_q[i]);
        end else begin
          cfg_d[i][0] = 1'b0;
        end
      end
      if (expire_s[i]) begin
        pend_d[i] = 1'b1;
      end else if (clr_wr_s[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
      if (cfg_wr_s[i]) begin
        cfg_d[i] = merge_cfg(cfg_q[i], csr_wmask[CNT_W-1:0], csr_wdata[CNT_W-1:0]);
        val_d[i] = reload_of(cfg_d[i]);
      end
    end
  end

  always_comb begin
    rdata_s = 32'd0;
    if (is_presc_s) begin
      rdata_s = 32'(presc_q);
    end else if (in_chan_s) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (ch_s == 12'(i)) begin
          case (reg_s)
            2'd0:    rdata_s = 32'(cfg_q[i]);
            2'd1:    rdata_s = 32'(val_q[i]);
            2'd3:    rdata_s = {30'd0, cfg_q[i][0], pend_q[i]};
            default: rdata_s = 32'd0;
          endcase
        end
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cfg_q[i] <= {CNT_W{1'b0}};
        val_q[i] <= {CNT_W{1'b0}};
      end
      pend_q  <= {NUM_TIMERS{1'b0}};
      presc_q <= {PRESC_W{1'b0}};
      pcnt_q  <= {PRESC_W{1'b0}};
    end else begin
      cfg_q   <= cfg_d;
      val_q   <= val_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign csr_hit       = in_map_s;
  assign csr_rdata     = rdata_s;
  assign timer_int     = pend_q;
  assign timer_int_any = |pend_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Self-checking bench for csr_timer_bank: directed scenarios with literal expectations,
// then random CSR traffic compared every cycle against a behavioural model.
module tb_csr_timer_bank;
  localparam int          NT    = 4;
  localparam logic [13:0] BASE  = 14'h0100;
  localparam logic [13:0] PADDR = BASE + 14'(4 * NT);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          csr_we = 1'b0;
  logic [13:0]   csr_num = 14'd0;
  logic [31:0]   csr_wmask = 32'd0;
  logic [31:0]   csr_wdata = 32'd0;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic [NT-1:0] timer_int;
  logic          timer_int_any;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  csr_timer_bank #(.NUM_TIMERS(NT), .CNT_W(32), .PRESC_W(8), .CSR_BASE(BASE)) dut (
    .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_hit(csr_hit), .timer_int(timer_int), .timer_int_any(timer_int_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Behavioural model: prescaler ticks are derived from the edge index since the last
  // PRESC write (or reset) instead of a down-counter.
  logic [31:0] m_cfg [NT];
  logic [31:0] m_val [NT];
  bit          m_pend [NT];
  logic [31:0] m_presc;
  longint      m_e;
  longint      m_w;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] m, input logic [31:0] d);
    return (d & m) | (o & ~m);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] n, output bit hit);
    int off;
    off = int'(n) - int'(BASE);
    hit = 1'b0;
    if (off < 0 || off > 4 * NT) return 32'd0;
    hit = 1'b1;
    if (off == 4 * NT) return m_presc;
    case (off % 4)
      0: return m_cfg[off / 4];
      1: return m_val[off / 4];
      3: return {30'd0, m_cfg[off / 4][0], m_pend[off / 4]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int off;
    bit pw, tk, en, per, ex, cw, cl;
    logic [31:0] oldc;
    off = int'(csr_num) - int'(BASE);
    pw = csr_we && (off == 4 * NT);
    tk = !pw && (m_e > m_w) && (((m_e - m_w) % (longint'(m_presc) + 1)) == 0);
    for (int i = 0; i < NT; i++) begin
      oldc = m_cfg[i];
      en   = oldc[0];
      per  = oldc[1];
      cw   = csr_we && off >= 0 && off < 4 * NT && off / 4 == i && off % 4 == 0;
      cl   = csr_we && off >= 0 && off < 4 * NT && off / 4 == i && off % 4 == 2 &&
             csr_wmask[0] && csr_wdata[0];
      ex   = tk && en && (m_val[i] == 0);
      if (tk && en) begin
        if (m_val[i] != 0) m_val[i] = m_val[i] - 1;
        else if (per) m_val[i] = oldc & 32'hFFFF_FFFC;
        else m_cfg[i][0] = 1'b0;
      end
      if (ex) m_pend[i] = 1'b1;
      else if (cl) m_pend[i] = 1'b0;
      if (cw) begin
        m_cfg[i] = mrg(oldc, csr_wmask, csr_wdata);
        m_val[i] = m_cfg[i] & 32'hFFFF_FFFC;
      end
    end
    if (pw) begin
      m_presc = mrg(m_presc, csr_wmask, csr_wdata) & 32'h0000_00FF;
      m_w = m_e;
    end
    m_e++;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NT; i++) begin
        m_cfg[i] = 32'd0;
        m_val[i] = 32'd0;
        m_pend[i] = 1'b0;
      end
      m_presc = 32'd0;
      m_e = 0;
      m_w = -1;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [31:0] pv;
    logic [31:0] ed;
    bit eh;
    if (cmp_on) begin
      pv = 32'd0;
      for (int i = 0; i < NT; i++) pv[i] = m_pend[i];
      ed = m_read(csr_num, eh);
      chk("cyc_timer_int", 32'(timer_int), pv);
      chk("cyc_int_any", 32'(timer_int_any), 32'(pv != 32'd0));
      chk("cyc_hit", 32'(csr_hit), 32'(eh));
      chk("cyc_rdata", csr_rdata, ed);
    end
  end

  function automatic logic [13:0] A(input int ch, input int r);
    return BASE + 14'(4 * ch + r);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] d);
    csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wdata = d;
    step();
    csr_we = 1'b0; csr_wmask = 32'd0; csr_wdata = 32'd0;
  endtask

  task automatic rd(input string nm, input logic [13:0] n, input logic [31:0] exp);
    csr_num = n;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int r;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    cmp_on = 1'b1;
    chk("rst_timer_int", 32'(timer_int), 32'd0);
    rd("rst_presc", PADDR, 32'd0);
    rd("rst_cfg0", A(0, 0), 32'd0);
    rd("rst_stat0", A(0, 3), 32'd0);

    // One-shot R=32 at PRESC=0.
    wr(A(0, 0), 32'hFFFF_FFFF, 32'h21);
    rd("ch0_val_load", A(0, 1), 32'd32);
    rise = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rise < 0 && timer_int[0]) rise = k;
      rd("ch0_val_count", A(0, 1), (k < 32) ? 32'(32 - k) : 32'd0);
    end
    chk("ch0_rise_delay", 32'(rise), 32'd33);
    rd("ch0_stat_done", A(0, 3), 32'h1);
    rd("ch0_cfg_done", A(0, 0), 32'h20);
    wr(A(0, 2), 32'h1, 32'h1);
    chk("ch0_clr", 32'(timer_int[0]), 32'd0);

    // Periodic R=8, clear between expiries.
    wr(A(1, 0), 32'hFFFF_FFFF, 32'h0B);
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      step();
      if (timer_int[1]) rise = k;
    end
    chk("ch1_first_period", 32'(rise), 32'd9);
    step();
    step();
    wr(A(1, 2), 32'h1, 32'h1);
    chk("ch1_clr", 32'(timer_int[1]), 32'd0);
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      step();
      if (timer_int[1]) rise = k;
    end
    chk("ch1_rerise", 32'(rise), 32'd6);
    wr(A(1, 0), 32'hFFFF_FFFF, 32'h0);
    wr(A(1, 2), 32'h1, 32'h1);
    chk("ch1_off_clr", 32'(timer_int[1]), 32'd0);

    // PRESC=3, CH2 R=8 loaded on a tick edge.
    wr(PADDR, 32'hFFFF_FFFF, 32'd3);
    step(); step(); step();
    wr(A(2, 0), 32'hFFFF_FFFF, 32'h09);
    rise = -1;
    for (int k = 1; k <= 50 && rise < 0; k++) begin
      step();
      if (timer_int[2]) rise = k;
    end
    chk("ch2_presc_rise", 32'(rise), 32'd36);
    rd("ch2_stat", A(2, 3), 32'h1);
    wr(A(2, 2), 32'h1, 32'h1);

    // PRESC rewrite: next tick exactly PRESC+1 edges later.
    wr(A(3, 0), 32'hFFFF_FFFF, 32'h401);
    wr(PADDR, 32'hFFFF_FFFF, 32'd2);
    rd("presc_rw_val0", A(3, 1), 32'd1024);
    step();
    rd("presc_rw_val1", A(3, 1), 32'd1024);
    step();
    rd("presc_rw_val2", A(3, 1), 32'd1024);
    step();
    rd("presc_rw_val3", A(3, 1), 32'd1023);
    wr(A(3, 0), 32'hFFFF_FFFF, 32'h0);
    wr(PADDR, 32'hFFFF_FFFF, 32'd0);

    // Expiry coinciding with CLR: set wins.
    wr(A(0, 0), 32'hFFFF_FFFF, 32'h05);
    repeat (4) step();
    wr(A(0, 2), 32'h1, 32'h1);
    chk("clr_vs_expiry", 32'(timer_int[0]), 32'd1);
    wr(A(0, 2), 32'h1, 32'h1);
    chk("clr_after", 32'(timer_int[0]), 32'd0);

    // Expiry coinciding with a CFG write that clears EN.
    wr(A(0, 0), 32'hFFFF_FFFF, 32'h05);
    repeat (4) step();
    wr(A(0, 0), 32'h1, 32'h0);
    chk("cfgwr_vs_expiry", 32'(timer_int[0]), 32'd1);
    rd("cfgwr_cfg", A(0, 0), 32'h04);
    rd("cfgwr_val", A(0, 1), 32'd4);
    wr(A(0, 2), 32'h1, 32'h1);

    // Masked write touches EN only.
    wr(A(1, 0), 32'hFFFF_FFFF, 32'h403);
    wr(A(1, 0), 32'h1, 32'h0);
    rd("mask_cfg", A(1, 0), 32'h402);
    rd("mask_val", A(1, 1), 32'h400);
    rd("mask_stat", A(1, 3), 32'h0);

    // Outside the map.
    wr(PADDR + 14'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_num = PADDR + 14'd1;
    #1;
    chk("oob_hit", 32'(csr_hit), 32'd0);
    chk("oob_rdata", csr_rdata, 32'd0);
    csr_num = BASE - 14'd1;
    #1;
    chk("below_hit", 32'(csr_hit), 32'd0);
    rd("presc_kept", PADDR, 32'd0);

    // Reset glitch during periodic run on all channels.
    for (int i = 0; i < NT; i++) wr(A(i, 0), 32'hFFFF_FFFF, 32'h07);
    repeat (7) step();
    resetn = 1'b0;
    #1;
    chk("glitch_int", 32'(timer_int), 32'd0);
    rd("glitch_val", A(2, 1), 32'd0);
    rd("glitch_cfg", A(2, 0), 32'd0);
    #3;
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("post_glitch_int", 32'(timer_int), 32'd0);
    end

    // Random CSR traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      csr_num = ($urandom_range(0, 15) == 0) ? BASE - 14'd1
                                              : BASE + 14'($urandom_range(0, 4 * NT + 2));
      if (r < 4) begin
        csr_we = 1'b1;
        csr_wmask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
        csr_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
        if (csr_num == PADDR) csr_wdata = 32'($urandom_range(0, 3));
      end else begin
        csr_we = 1'b0;
      end
      step();
    end
    csr_we = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
